drive_sequencer: RTL

Schedules the 2-bit drive-direction code (00 forward, 01 reverse, 10 left, 11 right) and the matching LEDR torque patterns. It shares the direction datapath between two requesters: a programmed step table with per-step dwell times, and a manual override from switches/keys. It sits between the board inputs and the LED torque display, and it is the single owner of `direc` and the left/right LED banks.

---
 rtl/drive_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/drive_sequencer.sv
// drive_sequencer: drives the direction code and LEDR torque banks from a step table or a manual override.
// Latency: one cycle from sampled inputs to the registered outputs.
// Backpressure: none. man_req pauses a running program and freezes its timers. Build option DRIVE_SEQUENCER_LOOP_EN wraps the program.
module drive_sequencer #(
  parameter int DEPTH    = 8,
  parameter int DWELL_W  = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                     timer,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [1:0]               prog_dir,
  input  logic [DWELL_W-1:0]       prog_dwell,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     man_req,
  input  logic [1:0]               man_dir,
  output logic [1:0]               direc,
  output logic [8:0]               left_LED,
  output logic [8:0]               right_LED,
  output logic                     busy,
  output logic                     done,
  output logic                     owner,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      presc, presc_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic [AW-1:0]      idx_nxt;
  logic               done_nxt, busy_nxt, owner_nxt;
  logic [1:0]         dir_nxt;
  logic [17:0]        leds_nxt;

  logic [1:0]         tbl_dir   [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];

  logic [AW-1:0]      nidx;
  logic               last_step;
  logic               tick;

  // {left, right} torque pattern for a direction code
  function automatic logic [17:0] led_pat(input logic [1:0] d);
    case (d)
      2'b00:   led_pat = {9'b000001111, 9'b000001111};
      2'b01:   led_pat = {9'b111100000, 9'b111100000};
      2'b10:   led_pat = {9'b000001100, 9'b000001111};
      default: led_pat = {9'b000001111, 9'b000001100};
    endcase
  endfunction

  assign nidx      = step_idx + AW'(1);
  assign last_step = (step_idx == AW'(DEPTH - 1)) || (tbl_dwell[nidx] == '0);
  assign tick      = (presc == PW'(TICK_DIV - 1));

  // Step table: only writable while idle so a running program never changes under itself
  always_ff @(posedge timer) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_dir[i]   <= '0;
        tbl_dwell[i] <= '0;
      end
    end else if (prog_we && state == S_IDLE) begin
      tbl_dir[prog_addr]   <= prog_dir;
      tbl_dwell[prog_addr] <= prog_dwell;
    end
  end

  // Next-state, step timing and output selection
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    dwell_nxt = dwell_cnt;
    idx_nxt   = step_idx;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          if (tbl_dwell[0] == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_RUN;
            idx_nxt   = '0;
            dwell_nxt = tbl_dwell[0];
            presc_nxt = '0;
          end
        end
      end
      S_RUN, S_PAUSE: begin
        if (stop) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
          presc_nxt = '0;
          dwell_nxt = '0;
        end else if (man_req) begin
          // timers frozen; the cycle that sees man_req does not count
          state_nxt = S_PAUSE;
        end else begin
          // a cycle leaving PAUSE counts so resumed time matches the remainder exactly
          state_nxt = S_RUN;
          if (!tick) begin
            presc_nxt = presc + PW'(1);
          end else begin
            presc_nxt = '0;
            if (dwell_cnt != DWELL_W'(1)) begin
              dwell_nxt = dwell_cnt - DWELL_W'(1);
            end else if (!last_step) begin
              idx_nxt   = nidx;
              dwell_nxt = tbl_dwell[nidx];
            end else begin
              done_nxt = 1'b1;
`ifdef DRIVE_SEQUENCER_LOOP_EN
              idx_nxt   = '0;
              dwell_nxt = tbl_dwell[0];
`else
              state_nxt = S_IDLE;
              idx_nxt   = '0;
              dwell_nxt = '0;
`endif
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    if (man_req) begin
      dir_nxt   = man_dir;
      owner_nxt = 1'b1;
      leds_nxt  = led_pat(man_dir);
    end else if (busy_nxt) begin
      dir_nxt   = tbl_dir[idx_nxt];
      owner_nxt = 1'b0;
      leds_nxt  = led_pat(tbl_dir[idx_nxt]);
    end else begin
      dir_nxt   = 2'b00;
      owner_nxt = 1'b0;
      leds_nxt  = '0;
    end
  end

  // Sequencer state and timers
  always_ff @(posedge timer) begin
    if (reset) begin
      state     <= S_IDLE;
      presc     <= '0;
      dwell_cnt <= '0;
      step_idx  <= '0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      dwell_cnt <= dwell_nxt;
      step_idx  <= idx_nxt;
    end
  end

  // Registered outputs
  always_ff @(posedge timer) begin
    if (reset) begin
      direc     <= '0;
      left_LED  <= '0;
      right_LED <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      direc     <= dir_nxt;
      left_LED  <= leds_nxt[17:9];
      right_LED <= leds_nxt[8:0];
      busy      <= busy_nxt;
      done      <= done_nxt;
      owner     <= owner_nxt;
    end
  end

endmodule
